// File: rtl/frequency_divider.sv
// Programmable integer clock divider.
// Produces a registered, glitch-free clk_out with a period of N clk cycles.
// The high phase is ceil(N/2) cycles and the low phase is floor(N/2) cycles.
// N is latched only at period boundaries. N < 2 parks the divider idle with clk_out low.
module frequency_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] N,
    output logic             clk_out
);

    // n_act == 0 doubles as the idle / pre-start marker.
    // A running divider always holds n_act >= 2.
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] cnt;

    // ceil(n/2), computed one bit wider so that n = 2^WIDTH-1 cannot overflow.
    function automatic logic [WIDTH:0] ceil_half(input logic [WIDTH-1:0] n);
        logic [WIDTH:0] nx;
        nx = {1'b0, n};
        return (nx + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    logic             running;
    logic             at_boundary;
    logic             n_ok;
    logic [WIDTH:0]   high_len;
    logic [WIDTH:0]   cnt_next_x;

    // Decode the period boundary and the next phase position.
    always_comb begin
        running     = (n_act >= WIDTH'(2));
        at_boundary = !running || (cnt == n_act - WIDTH'(1));
        n_ok        = (N >= WIDTH'(2));
        high_len    = ceil_half(n_act);
        cnt_next_x  = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Counter, latched factor and output flop advance together.
    // At a boundary, either a new period starts (clk_out rises) or the divider goes idle.
    // Inside a period, clk_out stays high while the new count is below ceil(n/2).
    always_ff @(posedge clk) begin
        if (reset) begin
            n_act   <= '0;
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (at_boundary) begin
            cnt <= '0;
            if (n_ok) begin
                n_act   <= N;
                clk_out <= 1'b1;
            end else begin
                n_act   <= '0;
                clk_out <= 1'b0;
            end
        end else begin
            cnt     <= cnt_next_x[WIDTH-1:0];
            clk_out <= (cnt_next_x < high_len);
        end
    end

endmodule

// File: tb/tb_frequency_divider.sv
// Directed testbench for frequency_divider.
// Every cycle of clk_out is compared against hand-derived high/low run lengths.
module tb_frequency_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] N;
    logic             clk_out;

    int n_tests = 0;
    int n_fail  = 0;

    frequency_divider #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .N       (N),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    // Single comparison point: count it and report a mismatch.
    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: clk_out=%b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect reps periods made of hi cycles high, then lo cycles low.
    task automatic wave(input string tag, input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) begin
                step();
                chk({tag, "_hi"}, clk_out, 1'b1);
            end
            for (int i = 0; i < lo; i++) begin
                step();
                chk({tag, "_lo"}, clk_out, 1'b0);
            end
        end
    endtask

    // Hold reset for one edge and check that the output clears.
    task automatic do_reset();
        reset = 1'b1;
        step();
        chk("rst", clk_out, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // N=4 from reset: the edge at 5 is a reset edge and E1 is the edge at 15.
        reset = 1'b1;
        N     = 8'd4;
        step();
        chk("rst0", clk_out, 1'b0);
        reset = 1'b0;
        wave("n4", 2, 2, 12);

        // N=5: high 3, low 2.
        N = 8'd5;
        do_reset();
        wave("n5", 3, 2, 6);

        // Change 4 -> 6 in the high phase: the 4-cycle period finishes first.
        N = 8'd4;
        do_reset();
        step();
        chk("sw_e1", clk_out, 1'b1);
        N = 8'd6;
        step();
        chk("sw_e2", clk_out, 1'b1);
        step();
        chk("sw_e3", clk_out, 1'b0);
        step();
        chk("sw_e4", clk_out, 1'b0);
        wave("n6", 3, 3, 3);

        // N=0, then N=1: idle. N=3 starts on its first edge.
        N = 8'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle0", clk_out, 1'b0);
        end
        N = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle1", clk_out, 1'b0);
        end
        N = 8'd3;
        wave("n3", 2, 1, 4);

        // Drop to N=1 mid-period: the current 3-cycle period completes, then idle.
        step();
        chk("drop_e1", clk_out, 1'b1);
        N = 8'd1;
        step();
        chk("drop_e2", clk_out, 1'b1);
        step();
        chk("drop_e3", clk_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_idle", clk_out, 1'b0);
        end

        // N=8 with a one-edge reset in the high phase: a full period restarts.
        N = 8'd8;
        do_reset();
        wave("n8", 4, 4, 1);
        step();
        chk("n8_e1", clk_out, 1'b1);
        step();
        chk("n8_e2", clk_out, 1'b1);
        reset = 1'b1;
        step();
        chk("n8_midrst", clk_out, 1'b0);
        reset = 1'b0;
        wave("n8r", 4, 4, 2);

        // N=2 toggles on every edge.
        N = 8'd2;
        do_reset();
        wave("n2", 1, 1, 5);

        // N=255: high 128, low 127, with no counter overflow.
        N = 8'd255;
        do_reset();
        wave("n255", 128, 127, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
